// File: rtl/rsa_modexp_engine_if.sv
// rsa_modexp_engine_if: key load, request and result handshake bundle for rsa_modexp_engine
interface rsa_modexp_engine_if #(
    parameter int W  = 16,
    parameter int EW = 16
);
    logic          key_we;
    logic [W-1:0]  key_n;
    logic [EW-1:0] key_e;
    logic [EW-1:0] key_d;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [W-1:0]  in_msg;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    modport master (
        output key_we, key_n, key_e, key_d, in_valid, in_mode, in_msg, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
    modport slave (
        input  key_we, key_n, key_e, key_d, in_valid, in_mode, in_msg, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: constant-time right-to-left msg^exp mod n over two bit-serial modular multipliers
module rsa_modexp_engine #(
    parameter int W  = 16,
    parameter int EW = 16
) (
    input logic               clk,
    input logic               rst,
    rsa_modexp_engine_if.slave bus
);
    localparam int JW = W > 1 ? $clog2(W) : 1;
    localparam int KW = EW > 1 ? $clog2(EW) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        r_state, w_next;
    logic [W-1:0]  r_n, r_base, r_res, r_accp, r_accs, r_data, w_p, w_s, w_res, w_n;
    logic [EW-1:0] r_e, r_d, r_exp, w_exp;
    logic [JW-1:0] r_j;
    logic [KW-1:0] r_k;
    logic          r_err, w_acc, w_bad, w_slot_end, w_last;
    // one interleaved step: acc = 2*acc (+a if b) mod n, kept below n; W+1 bits avoids overflow
    function automatic logic [W-1:0] mstep(input logic [W-1:0] acc, input logic [W-1:0] a,
                                           input logic b, input logic [W-1:0] n);
        logic [W:0] t;
        t = {acc, 1'b0};
        t = t >= {1'b0, n} ? t - {1'b0, n} : t;
        t = b ? t + {1'b0, a} : t;
        t = t >= {1'b0, n} ? t - {1'b0, n} : t;
        return t[W-1:0];
    endfunction
    always_comb begin
        w_n        = bus.key_we ? bus.key_n : r_n;
        w_exp      = bus.in_mode ? (bus.key_we ? bus.key_d : r_d) : (bus.key_we ? bus.key_e : r_e);
        w_acc      = bus.in_valid && r_state == IDLE;
        w_bad      = w_n < W'(2) || bus.in_msg >= w_n;
        w_p        = mstep(r_accp, r_res, r_base[r_j], r_n);
        w_s        = mstep(r_accs, r_base, r_base[r_j], r_n);
        w_slot_end = r_j == '0;
        w_last     = w_slot_end && r_k == KW'(EW - 1);
        w_res      = r_exp[0] ? w_p : r_res;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE ? (w_acc ? (w_bad ? DONE : RUN) : IDLE)
               : r_state == RUN  ? (w_last ? DONE : RUN)
               : (bus.out_ready ? IDLE : DONE);
    end
    always_comb begin
        bus.in_ready  = r_state == IDLE;
        bus.out_valid = r_state == DONE;
        bus.out_data  = r_data;
        bus.out_err   = r_err;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n    <= '0;
            r_e    <= '0;
            r_d    <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
            r_base <= '0;
            r_res  <= '0;
            r_exp  <= '0;
            r_accp <= '0;
            r_accs <= '0;
            r_j    <= '0;
            r_k    <= '0;
        end else if (r_state == IDLE) begin
            if (bus.key_we) begin
                r_n <= bus.key_n;
                r_e <= bus.key_e;
                r_d <= bus.key_d;
            end
            if (w_acc) begin
                r_base <= bus.in_msg;
                r_res  <= W'(1);
                r_exp  <= w_exp;
                r_accp <= '0;
                r_accs <= '0;
                r_j    <= JW'(W - 1);
                r_k    <= '0;
                r_data <= '0;
                r_err  <= w_bad;
            end
        end else if (r_state == RUN) begin
            r_accp <= w_slot_end ? '0 : w_p;
            r_accs <= w_slot_end ? '0 : w_s;
            r_j    <= w_slot_end ? JW'(W - 1) : r_j - 1'b1;
            // the product is always formed; only the exponent bit decides whether it is kept
            if (w_slot_end) begin
                r_base <= w_s;
                r_res  <= w_res;
                r_exp  <= r_exp >> 1;
                r_k    <= r_k + 1'b1;
            end
            if (w_last) r_data <= w_res;
        end
    end
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb_rsa_modexp_engine: vector table, randomized model comparison and corner sequences for rsa_modexp_engine
module tb_rsa_modexp_engine;
    localparam int W = 16, EW = 16, LAT = EW * W;
    typedef struct {
        int n, e, d;
        bit mode;
        int msg;
        bit err;
        int data;
        int lat;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0, checks = 0;
    always #5 clk = ~clk;
    rsa_modexp_engine_if #(.W(W), .EW(EW)) bus ();
    rsa_modexp_engine #(.W(W), .EW(EW)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    function automatic int model(input int m, input int e, input int n);
        longint r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * m) % n;
        return int'(r);
    endfunction
    task automatic load_key(input int n, input int e, input int d);
        @(negedge clk);
        bus.key_we = 1'b1;
        bus.key_n  = n[W-1:0];
        bus.key_e  = e[EW-1:0];
        bus.key_d  = d[EW-1:0];
        @(negedge clk);
        bus.key_we = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", bus.out_valid, 1);
    endtask
    task automatic start_wait(input bit mode, input int msg, input bit kw, output int lat);
        @(negedge clk);
        check("in_ready_before_req", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_msg   = msg[W-1:0];
        bus.key_we   = kw;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.key_we   = 1'b0;
        bus.in_msg   = ~bus.in_msg;
        bus.in_mode  = ~mode;
        wait_done(lat);
    endtask
    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask
    task automatic run_op(input bit mode, input int msg, input bit kw, output int data, output bit err, output int lat);
        start_wait(mode, msg, kw, lat);
        data = int'(bus.out_data);
        err  = bus.out_err;
        drain();
    endtask
    initial begin
        vec_t vt[$];
        int data, lat, c, n, e, d, msg, expd, d0;
        bit err, mode, e0, stable;
        int ms[5] = '{0, 1, 2, 7000, 10402};
        rst = 1'b1;
        bus.key_we = 0; bus.key_n = 0; bus.key_e = 0; bus.key_d = 0;
        bus.in_valid = 0; bus.in_mode = 0; bus.in_msg = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_err", bus.out_err, 0);
        rst = 1'b0;
        vt.push_back('{33, 3, 7, 0, 4, 0, 31, LAT});
        vt.push_back('{33, 3, 7, 1, 31, 0, 4, LAT});
        vt.push_back('{33, 3, 7, 0, 33, 1, 0, 0});
        vt.push_back('{1, 3, 7, 0, 0, 1, 0, 0});
        vt.push_back('{0, 3, 7, 1, 0, 1, 0, 0});
        vt.push_back('{33, 0, 7, 0, 5, 0, 1, LAT});
        vt.push_back('{33, 3, 7, 0, 0, 0, 0, LAT});
        vt.push_back('{33, 3, 7, 1, 1, 0, 1, LAT});
        vt.push_back('{10403, 71, 431, 0, 10403, 1, 0, 0});
        foreach (vt[i]) begin
            load_key(vt[i].n, vt[i].e, vt[i].d);
            run_op(vt[i].mode, vt[i].msg, 1'b0, data, err, lat);
            check($sformatf("vec%0d_data", i), data, vt[i].data);
            check($sformatf("vec%0d_err", i), err, vt[i].err);
            check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
        end
        load_key(10403, 71, 431);
        foreach (ms[i]) begin
            run_op(1'b0, ms[i], 1'b0, c, err, lat);
            check($sformatf("rsa_enc%0d", ms[i]), c, model(ms[i], 71, 10403));
            check($sformatf("rsa_enc_lat%0d", ms[i]), lat, LAT);
            run_op(1'b1, c, 1'b0, data, err, lat);
            check($sformatf("rsa_roundtrip%0d", ms[i]), data, ms[i]);
            check($sformatf("rsa_dec_lat%0d", ms[i]), lat, LAT);
        end
        for (int i = 0; i < 8; i++) begin
            n    = int'($urandom_range(2, 65535));
            e    = int'($urandom_range(0, 65535));
            d    = int'($urandom_range(0, 300));
            mode = 1'($urandom_range(0, 1));
            msg  = $urandom_range(0, 5) == 0 ? int'($urandom_range(n, 65535)) : int'($urandom_range(0, n - 1));
            expd = msg >= n ? 0 : model(msg, mode ? d : e, n);
            load_key(n, e, d);
            run_op(mode, msg, 1'b0, data, err, lat);
            check($sformatf("rnd%0d_data", i), data, expd);
            check($sformatf("rnd%0d_err", i), err, msg >= n);
            check($sformatf("rnd%0d_lat", i), lat, msg >= n ? 0 : LAT);
        end
        // backpressure followed by a back-to-back request
        load_key(33, 3, 7);
        start_wait(1'b0, 4, 1'b0, lat);
        d0 = int'(bus.out_data);
        e0 = bus.out_err;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || int'(bus.out_data) != d0 || bus.out_err !== e0 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_data", d0, 31);
        drain();
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        run_op(1'b1, 31, 1'b0, data, err, lat);
        check("b2b_data", data, 4);
        // key write during RUN must not disturb the running operation or the stored key
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_msg = 16'd4;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        bus.key_we = 1'b1; bus.key_n = 16'd10403; bus.key_e = 16'd71; bus.key_d = 16'd431;
        @(negedge clk);
        bus.key_we = 1'b0;
        wait_done(lat);
        check("run_keywe_data", bus.out_data, 31);
        drain();
        run_op(1'b0, 4, 1'b0, data, err, lat);
        check("run_keywe_kept", data, 31);
        // key write together with the request: new key applies
        bus.key_n = 16'd10403; bus.key_e = 16'd71; bus.key_d = 16'd431;
        run_op(1'b0, 7000, 1'b1, data, err, lat);
        check("same_cycle_key_data", data, model(7000, 71, 10403));
        check("same_cycle_key_err", err, 0);
        // reset in the middle of bit slot 5
        load_key(33, 3, 7);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_msg = 16'd4;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5 * W + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        run_op(1'b0, 5, 1'b0, data, err, lat);
        check("midrst_keys_cleared", err, 1);
        load_key(33, 3, 7);
        run_op(1'b0, 4, 1'b0, data, err, lat);
        check("midrst_fresh_data", data, 31);
        check("midrst_fresh_lat", lat, LAT);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
